// File: rtl/tl45_div32.sv
// Iterative restoring divider: one quotient bit per clock, signed/unsigned, hold-until-ack result.
// Optional early-out for |dividend| < |divisor| is enabled with TL45_DIV_EARLY_OUT_EN.
module tl45_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             signQ_q, signQ_d;
  logic             signR_q, signR_d;
  logic [WIDTH-1:0] outQuot_q, outQuot_d;
  logic [WIDTH-1:0] outRem_q, outRem_d;
  logic             outDbz_q, outDbz_d;

  logic             dvdNeg, dvsNeg;
  logic [WIDTH-1:0] dvdMag, dvsMag;
  logic [WIDTH-1:0] remShift;
  logic [WIDTH:0]   trial;

  assign dvdNeg = i_signed & i_dividend[WIDTH-1];
  assign dvsNeg = i_signed & i_divisor[WIDTH-1];
  assign dvdMag = dvdNeg ? (~i_dividend + 1'b1) : i_dividend;
  assign dvsMag = dvsNeg ? (~i_divisor + 1'b1) : i_divisor;

  // Trial subtraction as add of inverted divisor; the carry-out is "no borrow".
  assign remShift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign trial    = {1'b0, remShift} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};

  assign o_ready       = (state_q == IDLE);
  assign o_valid       = (state_q == DONE);
  assign o_quotient    = outQuot_q;
  assign o_remainder   = outRem_q;
  assign o_div_by_zero = outDbz_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      signQ_q   <= 1'b0;
      signR_q   <= 1'b0;
      outQuot_q <= '0;
      outRem_q  <= '0;
      outDbz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      signQ_q   <= signQ_d;
      signR_q   <= signR_d;
      outQuot_q <= outQuot_d;
      outRem_q  <= outRem_d;
      outDbz_q  <= outDbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    signQ_d   = signQ_q;
    signR_d   = signR_q;
    outQuot_d = outQuot_q;
    outRem_d  = outRem_q;
    outDbz_d  = outDbz_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          dvd_d   = dvdMag;
          dvs_d   = dvsMag;
          signQ_d = dvdNeg ^ dvsNeg;
          signR_d = dvdNeg;
          rem_d   = '0;
          quot_d  = '0;
          count_d = '0;
          if (i_divisor == '0) begin
            // Divide-by-zero result is published immediately with the raw dividend.
            outQuot_d = '1;
            outRem_d  = i_dividend;
            outDbz_d  = 1'b1;
            state_d   = DONE;
          end
`ifdef TL45_DIV_EARLY_OUT_EN
          else if (dvdMag < dvsMag) begin
            rem_d   = dvdMag;
            state_d = FIXUP;
          end
`endif
          else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d   = trial[WIDTH] ? trial[WIDTH-1:0] : remShift;
        quot_d  = {quot_q[WIDTH-2:0], trial[WIDTH]};
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        outQuot_d = signQ_q ? (~quot_q + 1'b1) : quot_q;
        outRem_d  = signR_q ? (~rem_q + 1'b1) : rem_q;
        outDbz_d  = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        if (i_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
